// File: rtl/fp32_divider_seq_pkg.sv
// Shared FP32 definitions for the sequential divider.
//   EXP_W / MAN_W  : IEEE 754 single-precision field widths
//   BIAS           : exponent bias
//   EXP_ALL_ONES   : exponent pattern used for the divide-by-zero result
//   CNT_INIT       : first value of the quotient-bit counter (25 bits total)
//   state_t        : divider FSM state encoding
package fp32_divider_seq_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] BIAS         = 8'd127;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

  localparam logic [4:0] CNT_INIT = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fp32_div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder entering this step (always < 2*divisor)
//   divisor : {1, divisor mantissa}
//   rem_out : remainder after the optional subtract, shifted left one place
//   q_bit   : quotient bit produced by this step (1 = subtract succeeded)
module fp32_div_step
  import fp32_divider_seq_pkg::*;
(
  input  logic [MAN_W+2:0] rem_in,
  input  logic [MAN_W:0]   divisor,
  output logic [MAN_W+2:0] rem_out,
  output logic             q_bit
);

  logic [MAN_W+2:0] trial;

  // 26-bit trial subtract: the top bit is the borrow, so a clear MSB means
  // the divisor fitted.
  assign trial   = rem_in - {2'b00, divisor};
  assign q_bit   = ~trial[MAN_W+2];
  assign rem_out = (q_bit ? trial : rem_in) << 1;

endmodule

// File: rtl/fp32_divider_seq.sv
// Sequential IEEE 754 single-precision divider (C = A / B).
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, only looked at while idle
//   A, B  : dividend / divisor, captured when start is accepted
//   busy  : high whenever the FSM is not idle
//   done  : one-cycle pulse, C valid in that cycle
//   C     : quotient, held until the next done
// Handshake: start is accepted on the rising edge where busy=0 and start=1;
// exactly one done pulse follows 27 edges later unless rst intervenes.
// Mantissa is truncated, exponent wraps modulo 256, denormals read as zero.
module fp32_divider_seq
  import fp32_divider_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] C
);

  state_t            state;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [MAN_W+2:0]  rem_q;
  logic [MAN_W+1:0]  quo_q;
  logic [4:0]        cnt_q;

  logic [MAN_W+2:0]  step_in;
  logic [MAN_W+2:0]  step_rem;
  logic              step_bit;

  logic              sign;
  logic [EXP_W-1:0]  exp_diff;
  logic [EXP_W-1:0]  norm_exp;
  logic [MAN_W-1:0]  norm_man;
  logic [31:0]       result;

  assign busy = (state != ST_IDLE);

  // The remainder register is cleared on accept; the first step instead
  // starts from the dividend significand {1, A man}.
  assign step_in = (cnt_q == CNT_INIT) ? {2'b00, 1'b1, a_q[MAN_W-1:0]} : rem_q;

  fp32_div_step u_step (
    .rem_in  (step_in),
    .divisor ({1'b1, b_q[MAN_W-1:0]}),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // Result formatting: q[24] tells whether the significand ratio was >= 1.
  always_comb begin
    sign     = a_q[31] ^ b_q[31];
    exp_diff = a_q[30:23] - b_q[30:23];
    norm_exp = quo_q[MAN_W+1] ? (exp_diff + BIAS) : (exp_diff + (BIAS - 8'd1));
    norm_man = quo_q[MAN_W+1] ? quo_q[MAN_W:1] : quo_q[MAN_W-1:0];
    result   = {sign, norm_exp, norm_man};
    if (b_q[30:23] == '0) begin
      result = {sign, EXP_ALL_ONES, {MAN_W{1'b0}}};
    end else if (a_q[30:23] == '0) begin
      result = {sign, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      C     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CNT_INIT;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[MAN_W:0], step_bit};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          C     <= result;
          state <= ST_DONE;
        end
        ST_DONE: begin
          // done is registered, so the pulse appears in the cycle after
          // DONE, which is already idle and may accept the next start.
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider_seq.sv
module tb_fp32_divider_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] C;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];

  fp32_divider_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .C     (C)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Reference: exact integer quotient of the significands, then the
  // normalisation / special-case rules applied directly.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                ea;
    int                eb;
    int                e;
    longint unsigned   n;
    longint unsigned   d;
    longint unsigned   q;
    logic [22:0]       man;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (eb == 0) return {s, 8'hFF, 23'd0};
    if (ea == 0) return {s, 31'd0};
    n = {40'd0, 1'b1, a[22:0]};
    n = n << 24;
    d = {40'd0, 1'b1, b[22:0]};
    q = n / d;
    if (q >= 64'd16777216) begin
      man = 23'((q >> 1) & 64'h7FFFFF);
      e   = ea - eb + 127;
    end else begin
      man = 23'(q & 64'h7FFFFF);
      e   = ea - eb + 126;
    end
    return {s, 8'(e & 255), man};
  endfunction

  // driver: wait for idle, present one request, log expectation at accept
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
      return;
    end
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(expv);
    acc_q.push_back(edge_cnt);
    start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [31:0] e;
    int          t;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%h required=no_done", C);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check("result", C, e);
          check("latency", 32'(edge_cnt - t), 32'd27);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_c", C, 32'd0);
    rst = 1'b0;

    // directed values
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    issue(32'hBFC00000, 32'h3F000000, 32'hC0400000);
    issue(32'h3F800000, 32'h00000000, 32'h7F800000);
    issue(32'h00000000, 32'hC0000000, 32'h80000000);
    issue(32'h00000000, 32'h00000000, 32'h7F800000);

    // random values, with zero exponents forced now and then
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:23] = 8'd0;
      if ($urandom_range(0, 7) == 0) rb[30:23] = 8'd0;
      issue(ra, rb, ref_div(ra, rb));
    end
    drain();

    // start held high: second accept must land exactly 28 edges later
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    n = edge_cnt;
    exp_q.push_back(32'h40400000);
    acc_q.push_back(n);
    A = 32'h3F800000;
    B = 32'h40400000;
    exp_q.push_back(32'h3EAAAAAA);
    acc_q.push_back(n + 28);
    repeat (28) @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // reset in the middle of CALC
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_c", C, 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_idle", {31'd0, busy}, 32'd0);
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
